// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the pipelined data memory.
package data_mem_pkg;

    localparam int unsigned DEF_DATA_W = 32'd8;
    localparam int unsigned DEF_ADDR_W = 32'd8;

    // Controller state: clearing the array after reset, or serving requests.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Number of byte lanes in a data word.
    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 32'd8;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Storage has no reset; only the read register is reset.
module data_mem_array #(
    parameter int unsigned DATA_W = 32'd8,
    parameter int unsigned ADDR_W = 32'd8,
    parameter int unsigned BE_W   = DATA_W / 32'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes into storage; contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Next read-register value: load on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_pl.sv
// Data memory with valid/ready request port, byte-enable writes and a
// one-cycle read response. After reset the array is optionally zeroed,
// one word per cycle, before requests are accepted.
module data_memory_pl
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned CLEAR_ON_RESET = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_done
);

    localparam int unsigned       BE_W     = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};
    localparam bit                DO_CLEAR = (CLEAR_ON_RESET != 32'd0);

    state_e            state_d,     state_q;
    logic [ADDR_W-1:0] clr_cnt_d,   clr_cnt_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic              req_ready_d, req_ready_q;
    logic              init_done_d, init_done_q;

    logic              accept_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [BE_W-1:0]   mem_be_s;
    logic [DATA_W-1:0] mem_rdata_s;

    assign accept_s = req_valid && req_ready_q;

    // Next-state logic: clear sweep in INIT, read-response tracking in READY.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            INIT: begin
                if (DO_CLEAR) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d   = READY;
                        clr_cnt_d = {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                if (accept_s && !req_we) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = INIT;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
        // Handshake outputs are registered copies of the next state.
        req_ready_d = (state_d == READY);
        init_done_d = (state_d == READY);
    end

    // Controller registers; reset restarts the clear sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
        end
    end

    // Array port mux: the clear sweep owns the port in INIT, requests in READY.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = req_addr;
        mem_wdata_s = req_wdata;
        mem_be_s    = req_be;
        if (state_q == INIT) begin
            mem_en_s    = DO_CLEAR;
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_q;
            mem_wdata_s = {DATA_W{1'b0}};
            mem_be_s    = {BE_W{1'b1}};
        end else begin
            mem_en_s    = accept_s;
            mem_we_s    = req_we;
            mem_addr_s  = req_addr;
            mem_wdata_s = req_wdata;
            mem_be_s    = req_be;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .be    (mem_be_s),
        .rdata (mem_rdata_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = mem_rdata_s;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_pl.sv
// Self-checking bench for data_memory_pl: three configurations, a vector
// table, hand-written reset/clear sequences and a randomized phase checked
// against a word-array reference model.
module tb_data_memory_pl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // dut_a: DATA_W=32, ADDR_W=4, clearing enabled
    logic        a_rst_n, a_valid, a_we, a_ready, a_rsp_valid, a_done;
    logic [3:0]  a_addr, a_be;
    logic [31:0] a_wdata, a_rdata;
    // dut_b: DATA_W=8, ADDR_W=8, clearing enabled
    logic        b_rst_n, b_valid, b_we, b_ready, b_rsp_valid, b_done;
    logic [7:0]  b_addr, b_wdata, b_rdata;
    logic [0:0]  b_be;
    // dut_c: DATA_W=8, ADDR_W=4, clearing disabled
    logic        c_rst_n, c_valid, c_we, c_ready, c_rsp_valid, c_done;
    logic [3:0]  c_addr;
    logic [7:0]  c_wdata, c_rdata;
    logic [0:0]  c_be;

    data_memory_pl #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .init_done(a_done));

    data_memory_pl #(.DATA_W(8), .ADDR_W(8), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .init_done(b_done));

    data_memory_pl #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(0)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .req_valid(c_valid), .req_ready(c_ready),
        .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .init_done(c_done));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model for dut_a: plain word array plus last read value.
    logic [31:0] mdl_mem [16];
    logic [31:0] mdl_rdata;
    logic        mdl_ready;

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
        mdl_rdata = 32'd0;
    endtask

    // One request cycle on dut_a, checked against the model afterwards.
    task automatic a_step(input logic v, input logic w, input logic [3:0] ad,
                          input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] mask;
        logic        exp_valid;
        a_valid = v; a_we = w; a_addr = ad; a_wdata = wd; a_be = be;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        if (v && mdl_ready) begin
            if (w) begin
                for (int i = 0; i < 4; i++) mask[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
                mdl_mem[ad] = (mdl_mem[ad] & ~mask) | (wd & mask);
            end else begin
                exp_valid = 1'b1;
                mdl_rdata = mdl_mem[ad];
            end
        end
        check("a_model_valid", 32'(a_rsp_valid), 32'(exp_valid));
        check("a_model_rdata", a_rdata, mdl_rdata);
        a_valid = 1'b0;
    endtask

    // Counts cycles with req_ready low on dut_a, pushing junk writes meanwhile.
    task automatic a_count_clear(output int cnt);
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 100) begin
            a_valid = 1'b1; a_we = 1'b1; a_addr = 4'($urandom);
            a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
            cnt++;
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 4'd3, 32'h0,        4'b0000, 1'b1, 32'h00BB_00DD};
        tbl[2]  = '{1'b1, 4'd1, 32'h11223344, 4'b1111, 1'b0, 32'h00BB_00DD};
        tbl[3]  = '{1'b1, 4'd2, 32'h55667788, 4'b1000, 1'b0, 32'h00BB_00DD};
        tbl[4]  = '{1'b1, 4'd4, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h00BB_00DD};
        tbl[5]  = '{1'b0, 4'd1, 32'h0,        4'b0000, 1'b1, 32'h1122_3344};
        tbl[6]  = '{1'b0, 4'd2, 32'h0,        4'b0000, 1'b1, 32'h5500_0000};
        tbl[7]  = '{1'b0, 4'd3, 32'h0,        4'b0000, 1'b1, 32'h00BB_00DD};
        tbl[8]  = '{1'b0, 4'd4, 32'h0,        4'b0000, 1'b1, 32'h0000_0000};
        tbl[9]  = '{1'b1, 4'd3, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0000_0000};
        tbl[10] = '{1'b0, 4'd3, 32'h0,        4'b0000, 1'b1, 32'hCAFE_F00D};

        a_rst_n = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 32'd0; a_be = 4'd0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_addr = 8'd0; b_wdata = 8'd0; b_be = 1'b0;
        c_rst_n = 1'b0; c_valid = 1'b0; c_we = 1'b0; c_addr = 4'd0; c_wdata = 8'd0; c_be = 1'b0;
        mdl_ready = 1'b0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;

        // Outputs while held in reset
        check("rst_ready",     32'(a_ready),     32'd0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rdata",     a_rdata,          32'd0);
        check("rst_init_done", 32'(a_done),      32'd0);

        // Initial clear: 16 cycles not ready, requests during clear ignored
        a_rst_n = 1'b1;
        a_count_clear(cnt);
        check("clear_len", 32'(cnt), 32'd16);
        check("clear_done", 32'(a_done), 32'd1);
        mdl_ready = 1'b1;
        for (int i = 0; i < 16; i++) a_step(1'b1, 1'b0, 4'(i), 32'd0, 4'd0);

        // Vector table: byte enables, zero enables, streaming reads, write-then-read
        for (int i = 0; i < 11; i++) begin
            a_step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
            check($sformatf("tbl%0d_valid", i), 32'(a_rsp_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].exp_rdata);
        end

        // Randomized traffic against the model
        repeat (300) begin
            a_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                   $urandom, 4'($urandom));
        end

        // Pending read cancelled by asynchronous reset
        a_step(1'b1, 1'b1, 4'd5, 32'h1234_5678, 4'hF);
        a_step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
        check("pend_valid", 32'(a_rsp_valid), 32'd1);
        #3 a_rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("async_rdata",     a_rdata,          32'd0);
        check("async_ready",     32'(a_ready),     32'd0);
        check("async_done",      32'(a_done),      32'd0);
        mdl_ready = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;

        // Reset at clr_cnt=7 restarts a full-length clear
        repeat (7) @(posedge clk);
        #1;
        check("mid_clear_ready", 32'(a_ready), 32'd0);
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        a_count_clear(cnt);
        check("restart_clear_len", 32'(cnt), 32'd16);
        mdl_clear();
        mdl_ready = 1'b1;
        for (int i = 0; i < 16; i++) a_step(1'b1, 1'b0, 4'(i), 32'd0, 4'd0);

        // dut_b: write 0x5A to 0xFF then read it on the next cycle
        b_rst_n = 1'b1;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 400) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("b_clear_len", 32'(cnt), 32'd256);
        b_valid = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 8'h5A; b_be = 1'b1;
        @(posedge clk); #1;
        check("b_write_no_rsp", 32'(b_rsp_valid), 32'd0);
        b_we = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("b_rd_valid", 32'(b_rsp_valid), 32'd1);
        check("b_rd_data",  {24'd0, b_rdata}, 32'h5A);
        @(posedge clk); #1;
        check("b_rd_one_cycle", 32'(b_rsp_valid), 32'd0);
        check("b_rd_hold",      {24'd0, b_rdata}, 32'h5A);

        // dut_c: no clear, ready one cycle after release, contents persist
        c_rst_n = 1'b1;
        check("c_ready_at_release", 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        check("c_ready_first_edge", 32'(c_ready), 32'd1);
        check("c_done_first_edge",  32'(c_done),  32'd1);
        c_valid = 1'b1; c_we = 1'b1; c_addr = 4'd9; c_wdata = 8'h33; c_be = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
        #3 c_rst_n = 1'b0;
        #1;
        check("c_rst_ready", 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        c_rst_n = 1'b1;
        check("c_release_ready", 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        check("c_ready_after", 32'(c_ready), 32'd1);
        c_valid = 1'b1; c_we = 1'b0; c_addr = 4'd9;
        @(posedge clk); #1;
        c_valid = 1'b0;
        check("c_persist_valid", 32'(c_rsp_valid), 32'd1);
        check("c_persist_data",  {24'd0, c_rdata}, 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_pl.md
DATA_MEMORY_PL -- requirements
Module: data_memory_pl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-003 The block SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero the whole array after reset, 0 = skip clearing.
REQ-004 The block SHALL derive BE_W = DATA_W/8 locally.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req_valid, input, 1: request present.
REQ-008 Port req_ready, output, 1: block can accept a request this cycle.
REQ-009 Port req_we, input, 1: 1 = write, 0 = read.
REQ-010 Port req_addr, input, ADDR_W: word address.
REQ-011 Port req_wdata, input, DATA_W: write data.
REQ-012 Port req_be, input, BE_W: byte enables for writes; bit i covers bits [8i+7:8i].
REQ-013 Port rsp_valid, output, 1: read data valid.
REQ-014 Port rsp_rdata, output, DATA_W: read data.
REQ-015 Port init_done, output, 1: high once clearing is complete.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-017 The FSM SHALL have states INIT (clearing the array) and READY; req_ready SHALL equal (state == READY).
REQ-018 INIT SHALL write zero to address clr_cnt each cycle, with clr_cnt counting 0 to 2**ADDR_W-1, and SHALL move to READY after writing the last address; INIT SHALL last exactly 2**ADDR_W cycles.
REQ-019 With CLEAR_ON_RESET=0, the FSM SHALL enter READY on the first rising edge after rst_n deasserts.
REQ-020 init_done SHALL be high exactly when state == READY.
REQ-021 An accepted write SHALL update only the bytes whose req_be bit is 1, at the accepting edge; rsp_valid SHALL NOT assert for writes.
REQ-022 An accepted write with req_be all-zero SHALL leave memory unchanged and SHALL be accepted normally.
REQ-023 An accepted read SHALL set rsp_valid=1 and rsp_rdata=mem[req_addr] for exactly the one cycle after the accepting edge (latency 1).
REQ-024 Back-to-back reads SHALL be accepted every cycle, giving one response per cycle in request order.
REQ-025 A read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-026 When no read was accepted on the previous edge, rsp_valid SHALL be 0 and rsp_rdata SHALL hold its last value.
REQ-027 Requests presented while req_ready=0 SHALL be ignored, with no effect on memory and no response.
REQ-028 There is no response backpressure: the consumer SHALL always accept rsp_valid.

Reset
REQ-029 Asserting rst_n low SHALL immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 and clr_cnt=0.
REQ-030 During reset the state SHALL be INIT when CLEAR_ON_RESET=1; when CLEAR_ON_RESET=0 it SHALL be INIT for one cycle, then READY.
REQ-031 Reset asserted during INIT SHALL restart clearing from address 0.
REQ-032 Reset asserted while a read response is pending SHALL cancel that response.
REQ-033 Array contents SHALL not be reset asynchronously; with CLEAR_ON_RESET=0 they SHALL persist across reset.

Structure
REQ-034 Package data_mem_pkg SHALL hold the FSM state type (INIT, READY) and the default DATA_W and ADDR_W constants.
REQ-035 The block SHALL contain exactly one sub-module, data_mem_array: a synchronous single-port array with byte-enable write and registered read; the FSM, clear counter and handshake SHALL live in the top level.

Verification
REQ-036 Bench SHALL check clear timing: ADDR_W=4, CLEAR_ON_RESET=1, release reset -> req_ready=0 for 16 cycles, then 1; reading all 16 addresses returns 0.
REQ-037 Bench SHALL check byte-enable write: DATA_W=32, write 0xAABBCCDD to addr 3 with be=4'b0101, then read addr 3 -> 0x00BB00DD one cycle after acceptance.
REQ-038 Bench SHALL check write-then-read: write 0x5A to addr 0xFF, read addr 0xFF on the next cycle -> rsp_rdata=0x5A, rsp_valid high for exactly 1 cycle.
REQ-039 Bench SHALL check streaming reads: reads of addr 1,2,3 on consecutive cycles -> three consecutive rsp_valid cycles with data in order.
REQ-040 Bench SHALL check reset during clear: assert rst_n low at clr_cnt=7, release -> clearing restarts at 0 and lasts a full 2**ADDR_W cycles.
REQ-041 Bench SHALL check persistence: CLEAR_ON_RESET=0, write 0x33 to addr 9, pulse reset -> req_ready=1 one cycle after release; read addr 9 returns 0x33.
